// File: rtl/clock_divider_pkg.sv
// Shared types, defaults and helpers for the clock divider bank and its sequential divider.
package clock_divider_pkg;

   localparam int unsigned DefBaseSpeed = 50000000;
   localparam int unsigned DefCntW      = 32;
   localparam int unsigned MaxCntW      = 64;

   typedef enum logic [1:0] {
      StIdle,
      StDiv,
      StDone
   } div_state_e;

   // A zero request stops the channel; a zero quotient means f > BASE/2, so run at clk/2.
   function automatic logic [MaxCntW-1:0] hp_clamp(input logic              f_zero,
                                                   input logic [MaxCntW-1:0] quo);
      logic [MaxCntW-1:0] res;
      if (f_zero) begin
         res = '0;
      end else if (quo == '0) begin
         res = {{(MaxCntW-1){1'b0}}, 1'b1};
      end else begin
         res = quo;
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; valid_o pulses exactly NUM_W cycles after start_i.
module seq_divider #(
   parameter int unsigned NUM_W = 32,
   parameter int unsigned DEN_W = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [NUM_W-1:0] num_i,
   input  logic [DEN_W-1:0] den_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [NUM_W-1:0] quo_o
);

   localparam int unsigned CntBits = $clog2(NUM_W + 1);

   logic [DEN_W-1:0]   rem_q, rem_d, den_q, den_d;
   logic [NUM_W-1:0]   num_q, num_d, quo_q, quo_d;
   logic [CntBits-1:0] cnt_q, cnt_d;
   logic               busy_q, busy_d, valid_q, valid_d;

   logic               first;
   logic [DEN_W-1:0]   step_rem, step_den;
   logic               step_bit, take;
   logic [DEN_W:0]     shifted, diff;
   logic [DEN_W-1:0]   rem_next;

   // The start cycle already computes the first quotient bit from the raw operands.
   always_comb begin
      first    = start_i & ~busy_q;
      step_rem = first ? '0 : rem_q;
      step_den = first ? den_i : den_q;
      step_bit = first ? num_i[NUM_W-1] : num_q[NUM_W-1];
      shifted  = {step_rem, step_bit};
      diff     = shifted - {1'b0, step_den};
      take     = (shifted >= {1'b0, step_den});
      rem_next = take ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
   end

   always_comb begin
      rem_d   = rem_q;
      den_d   = den_q;
      num_d   = num_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      if (first) begin
         den_d  = den_i;
         num_d  = num_i << 1;
         quo_d  = {{(NUM_W-1){1'b0}}, take};
         rem_d  = rem_next;
         cnt_d  = CntBits'(NUM_W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         num_d = num_q << 1;
         quo_d = {quo_q[NUM_W-2:0], take};
         rem_d = rem_next;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CntBits'(1)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q   <= '0;
         den_q   <= '0;
         num_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         rem_q   <= rem_d;
         den_q   <= den_d;
         num_q   <= num_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign quo_o   = quo_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of glitch-free 50% square-wave outputs; half-periods come from one shared sequential divider.
module clock_divider_bank
   import clock_divider_pkg::*;
#(
   parameter int unsigned BASE_SPEED = DefBaseSpeed,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned FREQ_W     = 20,
   parameter int unsigned CNT_W      = DefCntW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CHANNELS*FREQ_W-1:0] freq,
   input  logic [CHANNELS-1:0]        freq_load,
   output logic [CHANNELS-1:0]        clk_out,
   output logic [CHANNELS-1:0]        tick,
   output logic [CHANNELS-1:0]        done,
   output logic                       busy
);

   localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0][FREQ_W-1:0] req_freq_q, req_freq_d;
   logic [CHANNELS-1:0]             req_pend_q, req_pend_d;
   logic [CHANNELS-1:0][CNT_W-1:0]  hp_next_q, hp_next_d;
   logic [CHANNELS-1:0]             upd_pend_q, upd_pend_d;
   logic [CHANNELS-1:0]             done_q, done_d;
   logic                            busy_q, busy_d;
   div_state_e                      state_q, state_d;
   logic [IdxW-1:0]                 cur_ch_q, cur_ch_d;
   logic                            cur_zero_q, cur_zero_d;

   logic                            pick_valid;
   logic [IdxW-1:0]                 pick_idx;
   logic [CHANNELS-1:0]             pend_clr, upd_set, upd_apply;
   logic                            div_start, div_busy, div_valid;
   logic [FREQ_W:0]                 div_den;
   logic [CNT_W-1:0]                div_quo, hp_val;

   // Descending scan so the lowest pending index is the one left selected.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
         if (req_pend_q[i]) begin
            pick_valid = 1'b1;
            pick_idx   = IdxW'(i);
         end
      end
   end

   assign div_den = {req_freq_q[pick_idx], 1'b0};
   assign hp_val  = CNT_W'(hp_clamp(cur_zero_q, MaxCntW'(div_quo)));

   seq_divider #(
      .NUM_W (CNT_W),
      .DEN_W (FREQ_W + 1)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start),
      .num_i   (CNT_W'(BASE_SPEED)),
      .den_i   (div_den),
      .busy_o  (div_busy),
      .valid_o (div_valid),
      .quo_o   (div_quo)
   );

   always_comb begin
      state_d    = state_q;
      cur_ch_d   = cur_ch_q;
      cur_zero_d = cur_zero_q;
      hp_next_d  = hp_next_q;
      div_start  = 1'b0;
      pend_clr   = '0;
      upd_set    = '0;
      done_d     = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid && !div_busy) begin
               pend_clr[pick_idx] = 1'b1;
               cur_ch_d           = pick_idx;
               cur_zero_d         = (req_freq_q[pick_idx] == '0);
               div_start          = 1'b1;
               state_d            = StDiv;
            end
         end
         StDiv: begin
            // Result is committed on the last divide cycle so done lands in the DONE cycle.
            if (div_valid) begin
               hp_next_d[cur_ch_q] = hp_val;
               upd_set[cur_ch_q]   = 1'b1;
               done_d[cur_ch_q]    = 1'b1;
               state_d             = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A load arriving in the same cycle as its own pick stays pending: latest value wins.
   always_comb begin
      req_freq_d = req_freq_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (freq_load[i]) begin
            req_freq_d[i] = freq[i*FREQ_W +: FREQ_W];
         end
      end
      req_pend_d = (req_pend_q & ~pend_clr) | freq_load;
      upd_pend_d = (upd_pend_q & ~upd_apply) | upd_set;
      busy_d     = (state_d != StIdle) | (|req_pend_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_freq_q <= '0;
         req_pend_q <= '0;
         hp_next_q  <= '0;
         upd_pend_q <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         state_q    <= StIdle;
         cur_ch_q   <= '0;
         cur_zero_q <= 1'b0;
      end else begin
         req_freq_q <= req_freq_d;
         req_pend_q <= req_pend_d;
         hp_next_q  <= hp_next_d;
         upd_pend_q <= upd_pend_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         state_q    <= state_d;
         cur_ch_q   <= cur_ch_d;
         cur_zero_q <= cur_zero_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic [CNT_W-1:0] hp_q, hp_d, cnt_q, cnt_d;
      logic             out_q, out_d, tick_q, tick_d;
      logic             apply;

      // Updates only land with the output low: at a falling toggle, or at once when stopped.
      always_comb begin
         hp_d   = hp_q;
         cnt_d  = cnt_q;
         out_d  = out_q;
         tick_d = 1'b0;
         apply  = 1'b0;
         if (hp_q == '0) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (upd_pend_q[g]) begin
               hp_d  = hp_next_q[g];
               apply = 1'b1;
            end
         end else if (cnt_q == hp_q - 1'b1) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = ~out_q;
            if (out_q && upd_pend_q[g]) begin
               hp_d  = hp_next_q[g];
               apply = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hp_q   <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            hp_q   <= hp_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
         end
      end

      assign upd_apply[g] = apply;
      assign clk_out[g]   = out_q;
      assign tick[g]      = tick_q;
   end

   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank; done pulses are checked against a scoreboard queue.
module tb_clock_divider_bank;

   localparam int Ch  = 4;
   localparam int Fw  = 20;
   localparam int Cw  = 16;
   localparam int Lat = Cw + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [Ch*Fw-1:0] freq = '0;
   logic [Ch-1:0] freq_load = '0;
   logic [Ch-1:0] clk_out, tick, done;
   logic          busy;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int ch;
      int at;
   } exp_t;
   exp_t exp_q[$];

   clock_divider_bank #(
      .BASE_SPEED (1000),
      .CHANNELS   (Ch),
      .FREQ_W     (Fw),
      .CNT_W      (Cw)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .freq      (freq),
      .freq_load (freq_load),
      .clk_out   (clk_out),
      .tick      (tick),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < Ch; c++) begin
            if (done[c]) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("unexpected_done_ch%0d", c), cyc, -1);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("done_channel", c, e.ch);
                  check("done_cycle", cyc, e.at);
               end
            end
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_tick(input int c, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (tick[c]) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic load(input int c, input int f, input int exp_at);
      freq[c*Fw +: Fw] = Fw'(f);
      freq_load[c]     = 1'b1;
      if (exp_at >= 0) exp_q.push_back('{c, exp_at});
      @(negedge clk);
      freq_load = '0;
   endtask

   initial begin
      int t, a, b, t0, t1, d, low, f1, f2, b40, bad;

      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // ch0 at 100 Hz: H=5, first rise at done+1+5
      t = cyc;
      load(0, 100, t + Lat);
      check("busy_after_load", int'(busy), 1);
      wait_tick(0, 40, a);
      check("ch0_first_rise", a, t + Lat + 6);
      check("busy_idle_after_done", int'(busy), 0);
      wait_tick(0, 20, b);
      check("ch0_period", b - a, 10);
      wait_until(b + 4);
      check("ch0_high_last", int'(clk_out[0]), 1);
      wait_until(b + 5);
      check("ch0_low_first", int'(clk_out[0]), 0);

      // retune to 50 Hz mid-high: 10-cycle period finishes, one 15 gap, then 20
      wait_tick(0, 20, t0);
      check("ch0_period2", t0 - b, 10);
      wait_until(t0 + 2);
      load(0, 50, t0 + 2 + Lat);
      wait_tick(0, 20, a);
      check("retune_tick1", a - t0, 10);
      wait_tick(0, 20, a);
      check("retune_tick2", a - t0, 20);
      wait_tick(0, 30, a);
      check("retune_tick3", a - t0, 35);
      wait_tick(0, 30, a);
      check("retune_tick4", a - t0, 55);
      wait_until(t0 + 64);
      check("slow_high_last", int'(clk_out[0]), 1);
      wait_until(t0 + 65);
      check("slow_low_first", int'(clk_out[0]), 0);

      // stop: last rise still happens, output falls at the next falling edge and stays low
      wait_tick(0, 30, t1);
      check("slow_period", t1 - t0, 75);
      load(0, 0, t1 + Lat);
      wait_tick(0, 30, a);
      check("stop_last_rise", a - t1, 20);
      wait_until(t1 + 29);
      check("stop_high_last", int'(clk_out[0]), 1);
      wait_until(t1 + 30);
      check("stop_fall", int'(clk_out[0]), 0);
      wait_tick(0, 60, a);
      check("stop_no_tick", a, -1);
      check("stop_hold_low", int'(clk_out[0]), 0);

      // 600 Hz on ch3 clamps to H=1
      t = cyc;
      d = t + Lat;
      load(3, 600, d);
      wait_tick(3, 40, a);
      check("fast_first_rise", a - d, 2);
      wait_tick(3, 4, a);
      check("fast_tick2", a - d, 4);
      wait_until(d + 5);
      check("fast_low", int'(clk_out[3]), 0);
      wait_tick(3, 4, a);
      check("fast_tick3", a - d, 6);

      // simultaneous loads: ch1 (H=10) served first, ch2 (H=2) one slot later
      t = cyc;
      freq[1*Fw +: Fw] = Fw'(50);
      freq[2*Fw +: Fw] = Fw'(250);
      freq_load = 4'b0110;
      exp_q.push_back('{1, t + Lat});
      exp_q.push_back('{2, t + 2 * Lat});
      @(negedge clk);
      freq_load = '0;
      low = 0;
      f1  = -1;
      f2  = -1;
      b40 = -1;
      for (int k = t + 1; k <= t + 45; k++) begin
         wait_until(k);
         if (k <= t + 2 * Lat && !busy) low++;
         if (tick[1] && f1 < 0) f1 = k;
         if (tick[2] && f2 < 0) f2 = k;
         if (k == t + 40) b40 = int'(busy);
      end
      check("dual_busy_low_cycles", low, 0);
      check("dual_ch1_first_rise", f1, t + Lat + 11);
      check("dual_ch2_first_rise", f2, t + 2 * Lat + 3);
      check("dual_busy_after", b40, 0);

      // asynchronous reset in the middle of a divide
      t = cyc;
      load(0, 100, -1);
      wait_until(t + 6);
      #2 rst = 1'b1;
      #1;
      check("async_rst_clk_out", int'(clk_out), 0);
      check("async_rst_tick", int'(tick), 0);
      check("async_rst_done", int'(done), 0);
      check("async_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (clk_out != '0 || tick != '0 || busy) bad++;
      end
      check("post_reset_quiet", bad, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
